// File: rtl/tone_envelope_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tone_envelope_ctrl
// Purpose  : Frame-aligned ADSR envelope and square-wave tone controller that
//            produces the PWM duty value (t_on) for the sound generator DAC.
//            All musical state advances once per 2^N-clock PWM frame, on the
//            last clock of the frame, so the DAC duty never changes mid-period.
// Revision : 1.0 - initial release
// ============================================================================
module tone_envelope_ctrl #(
  parameter int N = 8,   // DAC bitwidth; frame length is 2^N clocks
  parameter int P = 12   // pitch counter width
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         gate,
  input  logic [P-1:0] pitch,
  input  logic [N-1:0] attack_step,
  input  logic [N-1:0] decay_step,
  input  logic [N-1:0] sustain,
  input  logic [N-1:0] release_step,
  output logic [N-1:0] t_on,
  output logic [N-1:0] env,
  output logic [2:0]   state,
  output logic         frame_end
);

  // Envelope state encoding (visible on the state port)
  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_ATTACK  = 3'd1;
  localparam logic [2:0] c_ST_DECAY   = 3'd2;
  localparam logic [2:0] c_ST_SUSTAIN = 3'd3;
  localparam logic [2:0] c_ST_RELEASE = 3'd4;

  localparam logic [N-1:0] c_ENV_MAX = {N{1'b1}};
  localparam logic [N-1:0] c_ENV_MIN = {N{1'b0}};
  localparam logic [N-1:0] c_FC_LAST = {N{1'b1}};
  localparam logic [N-1:0] c_FC_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [P-1:0] c_PC_ONE  = {{(P-1){1'b0}}, 1'b1};
  localparam logic [P-1:0] c_PC_ZERO = {P{1'b0}};

  // Registered state
  logic [N-1:0] r_fc;
  logic [2:0]   r_state;
  logic [N-1:0] r_env;
  logic [N-1:0] r_t_on;
  logic [P-1:0] r_pc;
  logic         r_ph;

  // Combinational next values (meaningful only when a frame ends)
  logic [2:0]   w_state_next;
  logic [N-1:0] w_env_next;
  logic [P-1:0] w_pc_next;
  logic         w_ph_next;
  logic [N-1:0] w_t_on_next;
  logic         w_frame_end;

  // Widened arithmetic so carries and borrows are visible for saturation
  logic [N:0]   w_sum_att;
  logic [N:0]   w_diff_dec;
  logic [N:0]   w_diff_rel;
  logic [N-1:0] w_env_att;
  logic [N-1:0] w_env_dec;
  logic [N-1:0] w_env_rel;
  logic [P-1:0] w_pitch_m1;

  // --------------------------------------------------------------------------
  // Frame counter: free-running, shares reset with the DAC counter so both
  // wrap on the same clock.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fc <= c_ENV_MIN;
    end else begin
      r_fc <= r_fc + c_FC_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Saturating envelope arithmetic shared by all states.
  // --------------------------------------------------------------------------
  always_comb begin
    w_sum_att  = {1'b0, r_env} + {1'b0, attack_step};
    w_diff_dec = {1'b0, r_env} - {1'b0, decay_step};
    w_diff_rel = {1'b0, r_env} - {1'b0, release_step};

    // Attack clamps at full scale on carry out.
    w_env_att = w_sum_att[N] ? c_ENV_MAX : w_sum_att[N-1:0];

    // Decay never drops below the sustain level (unsigned compare); a borrow
    // means the true result is negative, which is also below sustain.
    if (w_diff_dec[N] || (w_diff_dec[N-1:0] < sustain)) begin
      w_env_dec = sustain;
    end else begin
      w_env_dec = w_diff_dec[N-1:0];
    end

    // Release clamps at zero on borrow.
    w_env_rel = w_diff_rel[N] ? c_ENV_MIN : w_diff_rel[N-1:0];
  end

  // --------------------------------------------------------------------------
  // FSM state register: state and envelope advance together at frame end.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
      r_env   <= c_ENV_MIN;
    end else if (w_frame_end) begin
      r_state <= w_state_next;
      r_env   <= w_env_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic: a state entered this frame applies its own step
  // immediately, so the exit checks look at the freshly computed level.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_env_next   = r_env;
    case (r_state)
      c_ST_IDLE: begin
        w_env_next = c_ENV_MIN;
        if (gate) begin
          // Attack from zero lands exactly on attack_step.
          w_env_next   = attack_step;
          w_state_next = (attack_step == c_ENV_MAX) ? c_ST_DECAY : c_ST_ATTACK;
        end
      end

      c_ST_ATTACK: begin
        if (!gate) begin
          w_env_next   = w_env_rel;
          w_state_next = (w_env_rel == c_ENV_MIN) ? c_ST_IDLE : c_ST_RELEASE;
        end else begin
          w_env_next = w_env_att;
          if (w_env_att == c_ENV_MAX) begin
            w_state_next = c_ST_DECAY;
          end
        end
      end

      c_ST_DECAY: begin
        if (!gate) begin
          w_env_next   = w_env_rel;
          w_state_next = (w_env_rel == c_ENV_MIN) ? c_ST_IDLE : c_ST_RELEASE;
        end else begin
          w_env_next = w_env_dec;
          if (w_env_dec == sustain) begin
            w_state_next = c_ST_SUSTAIN;
          end
        end
      end

      c_ST_SUSTAIN: begin
        if (!gate) begin
          w_env_next   = w_env_rel;
          w_state_next = (w_env_rel == c_ENV_MIN) ? c_ST_IDLE : c_ST_RELEASE;
        end else begin
          // Follow the sustain input so level changes take effect live.
          w_env_next = sustain;
        end
      end

      c_ST_RELEASE: begin
        if (gate) begin
          // Retrigger: attack resumes from the current level, not from zero.
          w_env_next   = w_env_att;
          w_state_next = (w_env_att == c_ENV_MAX) ? c_ST_DECAY : c_ST_ATTACK;
        end else begin
          w_env_next = w_env_rel;
          if (w_env_rel == c_ENV_MIN) begin
            w_state_next = c_ST_IDLE;
          end
        end
      end

      default: begin
        // Unreachable codes recover to a silent idle.
        w_state_next = c_ST_IDLE;
        w_env_next   = c_ENV_MIN;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Tone divider next values: counts frames and toggles the square-wave
  // phase every pitch frames. Using >= means a pitch reduced below the
  // current count toggles on the very next frame instead of wrapping.
  // --------------------------------------------------------------------------
  always_comb begin
    w_pitch_m1 = pitch - c_PC_ONE;
    w_pc_next  = r_pc;
    w_ph_next  = r_ph;
    if ((r_state == c_ST_IDLE) || (pitch == c_PC_ZERO)) begin
      w_pc_next = c_PC_ZERO;
      w_ph_next = 1'b1;
    end else if (r_pc >= w_pitch_m1) begin
      w_pc_next = c_PC_ZERO;
      w_ph_next = ~r_ph;
    end else begin
      w_pc_next = r_pc + c_PC_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // FSM output logic: frame strobe and the gated duty value.
  // --------------------------------------------------------------------------
  always_comb begin
    w_frame_end = (r_fc == c_FC_LAST);
    w_t_on_next = w_ph_next ? w_env_next : c_ENV_MIN;
  end

  // --------------------------------------------------------------------------
  // Tone and duty registers: updated on the same edge as the envelope so
  // t_on always reflects the envelope and phase registered alongside it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc   <= c_PC_ZERO;
      r_ph   <= 1'b1;
      r_t_on <= c_ENV_MIN;
    end else if (w_frame_end) begin
      r_pc   <= w_pc_next;
      r_ph   <= w_ph_next;
      r_t_on <= w_t_on_next;
    end
  end

  assign t_on      = r_t_on;
  assign env       = r_env;
  assign state     = r_state;
  assign frame_end = w_frame_end;

endmodule
`default_nettype wire

// File: tb/tb_tone_envelope_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tone_envelope_ctrl
// Purpose  : Scoreboard bench for tone_envelope_ctrl. Each frame's stimulus
//            pushes the hand-computed envelope, duty and state into a queue;
//            a monitor pops and compares after every frame-end edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tone_envelope_ctrl;

  localparam int N = 8;
  localparam int P = 12;

  logic         clk = 1'b0;
  logic         reset;
  logic         gate;
  logic [P-1:0] pitch;
  logic [N-1:0] attack_step;
  logic [N-1:0] decay_step;
  logic [N-1:0] sustain;
  logic [N-1:0] release_step;
  logic [N-1:0] t_on;
  logic [N-1:0] env;
  logic [2:0]   state;
  logic         frame_end;

  typedef struct packed {
    logic [N-1:0] env;
    logic [N-1:0] ton;
    logic [2:0]   st;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  tone_envelope_ctrl #(.N(N), .P(P)) dut (
    .clk         (clk),
    .reset       (reset),
    .gate        (gate),
    .pitch       (pitch),
    .attack_step (attack_step),
    .decay_step  (decay_step),
    .sustain     (sustain),
    .release_step(release_step),
    .t_on        (t_on),
    .env         (env),
    .state       (state),
    .frame_end   (frame_end)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Monitor: after every frame-end edge, compare against the queued frame.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_end === 1'b1) begin
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          e = q.pop_front();
          check("env",   int'(env),   int'(e.env));
          check("t_on",  int'(t_on),  int'(e.ton));
          check("state", int'(state), int'(e.st));
        end
      end
    end
  end

  // Apply inputs for one frame, queue its expected result, wait for its edge.
  task automatic run_frame(input logic g, input int p,
                           input int ee, input int et, input int es);
    exp_t e;
    int   n;
    gate  = g;
    pitch = P'(p);
    e.env = N'(ee);
    e.ton = N'(et);
    e.st  = 3'(es);
    q.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_end !== 1'b1 && n < 300);
    if (frame_end !== 1'b1) begin
      check("frame_timeout", 0, 1);
      finish_run();
    end
    @(posedge clk);
    #2;
  endtask

  // Count clocks from reset release to the first frame_end.
  task automatic count_to_frame_end(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (frame_end !== 1'b1 && n < 400);
  endtask

  initial begin
    int n;
    reset = 1'b1; gate = 1'b0; pitch = '0;
    attack_step = '0; decay_step = '0; sustain = '0; release_step = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_env",   int'(env),       0);
    check("rst_t_on",  int'(t_on),      0);
    check("rst_state", int'(state),     0);
    check("rst_fe",    int'(frame_end), 0);
    @(negedge clk);
    reset = 1'b0;
    count_to_frame_end(n);
    check("first_frame_end_clocks", n, 255);

    // Attack / decay to sustain, no tone
    attack_step = 8'd64; decay_step = 8'd32; sustain = 8'd128; release_step = 8'd50;
    run_frame(1, 0,  64,  64, 1);
    run_frame(1, 0, 128, 128, 1);
    run_frame(1, 0, 192, 192, 1);
    run_frame(1, 0, 255, 255, 2);
    run_frame(1, 0, 223, 223, 2);
    run_frame(1, 0, 191, 191, 2);
    run_frame(1, 0, 159, 159, 2);
    run_frame(1, 0, 128, 128, 3);
    run_frame(1, 0, 128, 128, 3);

    // Release to idle
    run_frame(0, 0, 78, 78, 4);
    run_frame(0, 0, 28, 28, 4);
    run_frame(0, 0,  0,  0, 0);
    run_frame(0, 0,  0,  0, 0);

    // Fast attack to sustain, release one frame, retrigger from 78
    attack_step = 8'd128;
    run_frame(1, 0, 128, 128, 1);
    run_frame(1, 0, 255, 255, 2);
    run_frame(1, 0, 223, 223, 2);
    run_frame(1, 0, 191, 191, 2);
    run_frame(1, 0, 159, 159, 2);
    run_frame(1, 0, 128, 128, 3);
    run_frame(0, 0,  78,  78, 4);
    attack_step = 8'd64;
    run_frame(1, 0, 142, 142, 1);
    run_frame(1, 0, 206, 206, 1);
    run_frame(1, 0, 255, 255, 2);

    // Decay into sustain 200, then tone with pitch 3
    sustain = 8'd200;
    run_frame(1, 0, 223, 223, 2);
    run_frame(1, 0, 200, 200, 3);
    run_frame(1, 0, 200, 200, 3);
    run_frame(1, 3, 200, 200, 3);
    run_frame(1, 3, 200, 200, 3);
    run_frame(1, 3, 200,   0, 3);
    run_frame(1, 3, 200,   0, 3);
    run_frame(1, 3, 200,   0, 3);
    run_frame(1, 3, 200, 200, 3);
    run_frame(1, 3, 200, 200, 3);
    run_frame(1, 3, 200, 200, 3);
    run_frame(1, 3, 200,   0, 3);

    // Sustain follows its input live; pitch 0 forces phase high
    sustain = 8'd150;
    run_frame(1, 0, 150, 150, 3);

    // Release with underflow clamped at zero
    release_step = 8'd100;
    run_frame(0, 0, 50, 50, 4);
    run_frame(0, 0,  0,  0, 0);

    // Saturation: full-scale attack, full-scale sustain, zero release holds
    attack_step = 8'd255; sustain = 8'd255;
    run_frame(1, 0, 255, 255, 2);
    run_frame(1, 0, 255, 255, 3);
    release_step = 8'd0;
    run_frame(0, 0, 255, 255, 4);
    run_frame(0, 0, 255, 255, 4);
    run_frame(0, 0, 255, 255, 4);

    // Reset mid-frame at fc=100 from a full-scale release
    repeat (100) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_env",   int'(env),       0);
    check("mid_rst_t_on",  int'(t_on),      0);
    check("mid_rst_state", int'(state),     0);
    check("mid_rst_fe",    int'(frame_end), 0);
    @(negedge clk);
    reset = 1'b0;
    count_to_frame_end(n);
    check("mid_rst_frame_end_clocks", n, 255);
    check("queue_drained", q.size(), 0);

    finish_run();
  end

endmodule
`default_nettype wire

// File: doc/tone_envelope_ctrl.md
# tone_envelope_ctrl

Controller that sequences the PWM DAC of the sound generator. It runs a frame counter aligned to the DAC's `2^N`-clock PWM period, an ADSR envelope state machine driven by a note gate, and a square-wave tone divider. Once per frame it computes the duty value `t_on`, which feeds the `dac` instance in `tt_um_soundgen` in place of the constant duty.

## Interface
- `N`, 8: DAC bitwidth; width of `t_on`, envelope, and step inputs; PWM frame is `2^N` clocks.
- `P`, 12: pitch counter width.

- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high reset.
- `gate`, in, 1: note gate, level-sensitive; 1 = note held.
- `pitch`, in, P: tone half-period in frames; 0 = no tone (envelope only, phase held 1).
- `attack_step`, in, N: envelope increment per frame in ATTACK.
- `decay_step`, in, N: envelope decrement per frame in DECAY.
- `sustain`, in, N: sustain level.
- `release_step`, in, N: envelope decrement per frame in RELEASE.
- `t_on`, out, N: registered duty value to the DAC.
- `env`, out, N: registered envelope level.
- `state`, out, 3: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- `frame_end`, out, 1: high on the last clock of each frame.

## Operation
- **Frame counter `fc`** (N bits):
  - Increments every clock and wraps from `2^N-1` to 0.
  - `frame_end = (fc == 2^N-1)`, combinational from the register.
  - `reset` is shared with the DAC, so both counters stay aligned.
- **Update rule:**
  - All of the following change only on the clock edge where `frame_end=1`: `state`, `env`, pitch counter, phase, and `t_on`.
  - All inputs are sampled only at that edge.
- **State machine** (next state and new env computed together at `frame_end`; a new state's step applies in the same frame):
  - IDLE:
    - env=0.
    - gate=1 → ATTACK, env=attack_step.
  - ATTACK:
    - gate=0 → RELEASE, env=sat0(env−release_step).
    - Otherwise env=min(env+attack_step, 2^N−1). Reaching `2^N−1` → DECAY.
  - DECAY:
    - gate=0 → RELEASE as above.
    - Otherwise env=max(env−decay_step, sustain). Reaching `sustain` → SUSTAIN.
    - `sustain=2^N−1` → SUSTAIN on the first DECAY frame.
  - SUSTAIN:
    - env=sustain, tracking input changes each frame.
    - gate=0 → RELEASE, env=sat0(env−release_step).
  - RELEASE:
    - gate=1 → ATTACK, env=min(env+attack_step, max). This is a retrigger from the current level.
    - Otherwise env=sat0(env−release_step). Reaching 0 → IDLE.
  - Zero step values: a zero step holds the level. The state changes only on a gate edge.
  - Illegal state codes (5–7) → IDLE, env=0.
- **Arithmetic:**
  - Use N+1-bit sum/difference with saturation at `2^N−1` and at 0.
  - The comparison against `sustain` is unsigned.
- **Tone divider:**
  - Pitch counter `pc` (P bits), phase bit `ph`.
  - In IDLE, or when pitch=0: pc=0, ph=1.
  - Otherwise, at frame_end:
    - if `pc >= pitch−1`: pc=0 and ph toggles;
    - else pc increments.
  - Shrinking `pitch` mid-count toggles at the next frame_end.
- **Output:** `t_on = ph_next ? env_next : 0`, where both are the values registered at the same edge.

## Timing
- **Reset values:**
  - fc=0, state=IDLE, env=0, t_on=0, pc=0, ph=1.
  - frame_end=0 until the 255th clock after reset release, with N=8.
- **Latency:** gate or parameter change → effect on `env`/`t_on` at the next frame_end edge. Worst case is `2^N` clocks.
- **Stability:** `t_on` is constant for whole frames. It changes exactly when the DAC counter wraps, so no PWM glitch is possible.
- **Reset mid-frame:** all registers return to reset values on the next edge, and the frame restarts at fc=0.
- **Gate pulses:** a gate pulse shorter than a frame is seen only if it is high at a frame_end edge.

## Test plan
All scenarios use N=8, so one frame is 256 clocks.

1. **Reset mid-frame:** assert reset at fc=100 → next clock all outputs 0, state=0, and first frame_end exactly 255 clocks after release.
2. **Attack/decay to sustain:** gate=1, pitch=0, attack=64, decay=32, sustain=128 → env at successive frame_ends: 64, 128, 192, 255 (DECAY), 223, 191, 159, 128 (SUSTAIN). `t_on` equals env throughout.
3. **Release to idle:** from scenario 2, drop gate with release=50 → env 78, 28, 0; state RELEASE, RELEASE, IDLE.
4. **Retrigger:** drop gate, then raise it at env=78 in RELEASE, attack=64 → next frame env=142, state=ATTACK.
5. **Tone divider:** sustain=200 held in SUSTAIN, pitch=3 → `t_on` repeats 200, 200, 200, 0, 0, 0 per frame.
6. **Saturation:** attack=255, sustain=255 → env=255 (DECAY) after frame 1, then SUSTAIN with env=255 after frame 2. release=0 with gate low holds RELEASE at 255 indefinitely.
